uart_rx_param: RTL

- Parametrised UART receiver; successor to the fixed 8N1, 115200 bps receiver.
- Converts the asynchronous serial line into parallel words with a valid/ready output handshake.
- Configurable baud rate, data width, parity, stop bits and oversampling.
- Reports framing, parity and overrun errors; sits between the pad and the command decoder / RX FIFO.

---
 rtl/uart_rx_param.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled majority vote, valid/ready output and error flags.
// Define UART_RX_BREAK_DET_EN to enable break detection on rx_break.
module uart_rx_param #(
  parameter int SYS_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_break
);

  localparam int DIV_RAW = SYS_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = $clog2(DIV + 1);
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = ^d;
  endfunction

  logic [1:0]           sync_r;
  logic                 prev_r;
  logic [PW-1:0]        pre_r;
  logic [SW-1:0]        smp_r;
  logic                 samp_a_r, samp_b_r;
  logic [BW-1:0]        bit_r;
  logic                 stop_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_r, ferr_r;
  logic [2:0]           state_r, state_n;

  logic rxd_s, fall_s, tick_s, dec_s, end_s, maj_s;
  logic exp_par_s, fe_now_s, done_s, break_s;

  assign rxd_s     = sync_r[1];
  assign fall_s    = prev_r & ~rxd_s;
  assign tick_s    = (pre_r == PRE_LAST);
  assign dec_s     = tick_s && (smp_r == SMP_C);
  assign end_s     = tick_s && (smp_r == SMP_LAST);
  assign maj_s     = (samp_a_r & samp_b_r) | (samp_a_r & rxd_s) | (samp_b_r & rxd_s);
  assign exp_par_s = (PARITY == 1) ? ~parity_of(shift_r) : parity_of(shift_r);
  assign fe_now_s  = ferr_r | ~maj_s;
  assign done_s    = (state_r == S_STOP) && dec_s && (stop_r == STOP_LAST) && !break_s;

`ifdef UART_RX_BREAK_DET_EN
  logic zero_r;
  assign break_s = (state_r == S_STOP) && dec_s && (stop_r == 1'b0) && zero_r && !maj_s;

  // Tracks whether every data/parity sample of the current frame was 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
    end else if (state_r == S_START) begin
      zero_r <= 1'b1;
    end else if ((state_r == S_DATA || state_r == S_PAR) && dec_s && maj_s) begin
      zero_r <= 1'b0;
    end
  end
`else
  assign break_s = 1'b0;
`endif

  // Two-flop synchroniser and edge history, idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], uart_rxd};
      prev_r <= rxd_s;
    end
  end

  // Prescaler, realigned to the start edge so samples land mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= '0;
    end else if ((state_r == S_IDLE && fall_s) || tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (fall_s) state_n = S_START;
        else        state_n = S_IDLE;
      end
      S_START: begin
        if (dec_s && maj_s) state_n = S_IDLE;
        else if (end_s)     state_n = S_DATA;
        else                state_n = S_START;
      end
      S_DATA: begin
        if (end_s && bit_r == BIT_LAST) state_n = (PARITY != 0) ? S_PAR : S_STOP;
        else                            state_n = S_DATA;
      end
      S_PAR: begin
        if (end_s) state_n = S_STOP;
        else       state_n = S_PAR;
      end
      S_STOP: begin
        // Leave at the mid-point of the last stop bit so back-to-back frames are caught
        if (break_s)                     state_n = S_WAIT;
        else if (done_s)                 state_n = fe_now_s ? S_WAIT : S_IDLE;
        else                             state_n = S_STOP;
      end
      S_WAIT: begin
        if (rxd_s) state_n = S_IDLE;
        else       state_n = S_WAIT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_n;
  end

  // Sample/bit counters, vote samples and frame accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_r    <= '0;
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
      bit_r    <= '0;
      stop_r   <= 1'b0;
      shift_r  <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      if (state_r == S_IDLE)  smp_r <= '0;
      else if (tick_s)        smp_r <= (smp_r == SMP_LAST) ? '0 : smp_r + SW'(1);
      if (tick_s && smp_r == SMP_A) samp_a_r <= rxd_s;
      if (tick_s && smp_r == SMP_B) samp_b_r <= rxd_s;
      if (state_r != S_DATA) bit_r <= '0;
      else if (end_s)        bit_r <= bit_r + BW'(1);
      if (state_r != S_STOP) stop_r <= 1'b0;
      else if (end_s)        stop_r <= 1'b1;
      if (state_r == S_DATA && dec_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
      if (state_r == S_START)                 perr_r <= 1'b0;
      else if (state_r == S_PAR && dec_s)     perr_r <= maj_s ^ exp_par_s;
      if (state_r == S_START)                 ferr_r <= 1'b0;
      else if (state_r == S_STOP && dec_s && !maj_s) ferr_r <= 1'b1;
    end
  end

  // Output word register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      rx_break   <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      rx_break <= break_s;
      if (done_s && (!rx_valid || rx_ready)) begin
        rx_data    <= shift_r;
        rx_valid   <= 1'b1;
        frame_err  <= fe_now_s;
        parity_err <= (PARITY != 0) ? perr_r : 1'b0;
      end else begin
        if (done_s)               overrun  <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule
